// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types, sizing helpers and border test for the Canny gradient sequencer
package canny_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

    localparam int DEF_WIDTH       = 512;
    localparam int DEF_DEPTH       = 638;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int EXP_WINDOWS     = (DEF_WIDTH - DEF_KERNEL_SIZE + 1) * (DEF_DEPTH - DEF_KERNEL_SIZE + 1);
    localparam int DEF_CNT_W       = $clog2(DEF_WIDTH * DEF_DEPTH) + 1;

    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width * depth) + 1;
    endfunction

    // A window is border when it still overlaps the first KERNEL_SIZE-1 rows or columns.
    function automatic logic is_border(input int row, input int col, input int kernel_size);
        return (row < kernel_size - 1) || (col < kernel_size - 1);
    endfunction

endpackage

// File: rtl/grad_frame_sequencer_pix_pos_counter.sv
// rtl/grad_frame_sequencer_pix_pos_counter.sv - col/row position counter with line and frame wrap
module pix_pos_counter #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 638,
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [POS_W-1:0] col_o,
    output logic [POS_W-1:0] row_o,
    output logic             eol_o,
    output logic             eof_o
);

    localparam logic [POS_W-1:0] COL_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] ROW_LAST = POS_W'(DEPTH - 1);

    logic [POS_W-1:0] col_q;
    logic [POS_W-1:0] row_q;

    assign col_o = col_q;
    assign row_o = row_q;
    assign eol_o = (col_q == COL_LAST);
    assign eof_o = eol_o && (row_q == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            if (eol_o) begin
                col_q <= '0;
                row_q <= eof_o ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/grad_frame_sequencer.sv
// rtl/grad_frame_sequencer.sv - frame sequencer for the Sobel filter; GRAD_SEQ_ABORT_EN adds abort_i/abort_done_o
module grad_frame_sequencer
    import canny_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int DEPTH       = 638,
    parameter int KERNEL_SIZE = 3,
    parameter int PIPE_LAT    = 24,
    parameter int TMO_SLACK   = 8,
    parameter int POS_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic             pix_valid_i,
    input  logic             filt_data_en_i,
`ifdef GRAD_SEQ_ABORT_EN
    input  logic             abort_i,
    output logic             abort_done_o,
`endif
    output logic             filt_start_o,
    output logic             filt_clken_o,
    output logic             filt_invalid_o,
    output logic [POS_W-1:0] col_o,
    output logic [POS_W-1:0] row_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             cnt_err_o,
    output logic             ovr_err_o
);

    localparam int CNT_W   = cnt_width(WIDTH, DEPTH);
    localparam int TMO_LIM = PIPE_LAT + TMO_SLACK;
    localparam int TMR_W   = $clog2(TMO_LIM + 1);
    localparam logic [POS_W-1:0] PRIME_LAST_ROW = POS_W'(KERNEL_SIZE - 2);
    localparam logic [TMR_W-1:0] TMR_LAST       = TMR_W'(TMO_LIM - 1);

    seq_state_t       state_q;
    logic [CNT_W-1:0] iss_cnt_q;
    logic [CNT_W-1:0] ret_cnt_q;
    logic [TMR_W-1:0] tmr_q;
    logic             filt_start_q;
    logic             filt_clken_q;
    logic             filt_invalid_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             cnt_err_q;
    logic             ovr_err_q;

    logic             abort_hit;
    logic             accept;
    logic             border;
    logic             pos_clr;
    logic             eol;
    logic             eof;

`ifdef GRAD_SEQ_ABORT_EN
    logic abort_done_q;
    assign abort_hit    = abort_i && (state_q == ST_PRIME || state_q == ST_RUN || state_q == ST_FLUSH);
    assign abort_done_o = abort_done_q;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept  = pix_valid_i && (state_q == ST_PRIME || state_q == ST_RUN) && !abort_hit;
    assign border  = is_border(32'(row_o), 32'(col_o), KERNEL_SIZE);
    assign pos_clr = (state_q == ST_IDLE && frame_start_i) || abort_hit;

    pix_pos_counter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .POS_W (POS_W)
    ) u_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (pos_clr),
        .en_i  (accept),
        .col_o (col_o),
        .row_o (row_o),
        .eol_o (eol),
        .eof_o (eof)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            iss_cnt_q      <= '0;
            ret_cnt_q      <= '0;
            tmr_q          <= '0;
            filt_start_q   <= 1'b0;
            filt_clken_q   <= 1'b0;
            filt_invalid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            cnt_err_q      <= 1'b0;
            ovr_err_q      <= 1'b0;
`ifdef GRAD_SEQ_ABORT_EN
            abort_done_q   <= 1'b0;
`endif
        end else begin
            filt_clken_q   <= accept;
            filt_invalid_q <= accept && border;
            frame_done_q   <= 1'b0;
`ifdef GRAD_SEQ_ABORT_EN
            abort_done_q   <= abort_hit;
`endif
            if ((frame_start_i && state_q != ST_IDLE) || (filt_data_en_i && state_q == ST_IDLE)) begin
                ovr_err_q <= 1'b1;
            end
            if (accept && !border) begin
                iss_cnt_q <= iss_cnt_q + 1'b1;
            end
            if (filt_data_en_i && state_q != ST_IDLE) begin
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        state_q      <= ST_PRIME;
                        iss_cnt_q    <= '0;
                        ret_cnt_q    <= '0;
                        cnt_err_q    <= 1'b0;
                        filt_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (accept && eol && row_o == PRIME_LAST_ROW) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && eof) begin
                        state_q <= ST_FLUSH;
                        tmr_q   <= '0;
                    end
                end
                ST_FLUSH: begin
                    // Equality is judged on the count before this cycle's beat, so a beat
                    // arriving once everything is back is an extra return.
                    if (ret_cnt_q == iss_cnt_q) begin
                        state_q      <= ST_DONE;
                        filt_start_q <= 1'b0;
                        frame_done_q <= 1'b1;
                        if (filt_data_en_i) begin
                            cnt_err_q <= 1'b1;
                        end
                    end else if (filt_data_en_i) begin
                        tmr_q <= '0;
                    end else if (tmr_q == TMR_LAST) begin
                        state_q      <= ST_DONE;
                        filt_start_q <= 1'b0;
                        frame_done_q <= 1'b1;
                        cnt_err_q    <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (abort_hit) begin
                state_q        <= ST_IDLE;
                iss_cnt_q      <= '0;
                ret_cnt_q      <= '0;
                tmr_q          <= '0;
                filt_start_q   <= 1'b0;
                filt_clken_q   <= 1'b0;
                filt_invalid_q <= 1'b0;
                busy_q         <= 1'b0;
            end
        end
    end

    assign filt_start_o   = filt_start_q;
    assign filt_clken_o   = filt_clken_q;
    assign filt_invalid_o = filt_invalid_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign cnt_err_o      = cnt_err_q;
    assign ovr_err_o      = ovr_err_q;

endmodule

// File: tb/tb_grad_frame_sequencer.sv
// tb/tb_grad_frame_sequencer.sv - self-checking bench for grad_frame_sequencer on an 8x6 frame
module tb_grad_frame_sequencer;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int K  = 3;
    localparam int PL = 24;
    localparam int SL = 8;
    localparam int NPIX = W * D;

    localparam int P_IDLE  = 0;
    localparam int P_ACC   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       pix_valid;
    logic       filt_data_en;
    logic       filt_start;
    logic       filt_clken;
    logic       filt_invalid;
    logic [9:0] col;
    logic [9:0] row;
    logic       busy;
    logic       frame_done;
    logic       cnt_err;
    logic       ovr_err;
`ifdef GRAD_SEQ_ABORT_EN
    logic       abort;
    logic       abort_done;
`endif

    grad_frame_sequencer #(
        .WIDTH       (W),
        .DEPTH       (D),
        .KERNEL_SIZE (K),
        .PIPE_LAT    (PL),
        .TMO_SLACK   (SL),
        .POS_W       (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start_i  (frame_start),
        .pix_valid_i    (pix_valid),
        .filt_data_en_i (filt_data_en),
`ifdef GRAD_SEQ_ABORT_EN
        .abort_i        (abort),
        .abort_done_o   (abort_done),
`endif
        .filt_start_o   (filt_start),
        .filt_clken_o   (filt_clken),
        .filt_invalid_o (filt_invalid),
        .col_o          (col),
        .row_o          (row),
        .busy_o         (busy),
        .frame_done_o   (frame_done),
        .cnt_err_o      (cnt_err),
        .ovr_err_o      (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: pixel index, issued/returned beats, drain idle time, sticky flags.
    int   m_ph, m_n, m_iss, m_ret, m_idle;
    logic m_cerr, m_ovr;
    logic e_clk, e_inv, e_abd;

    // Filter model: delay line of valid beats, optional dropped beat.
    logic dl [PL];
    int   beat_no, drop_idx;

    // Per-frame tallies of observed DUT behaviour.
    int n_clk, n_val, n_inv, n_done, n_de, n_abd;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic bdr(input int n);
        return ((n / W) < K - 1) || ((n % W) < K - 1);
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_n = 0; m_iss = 0; m_ret = 0; m_idle = 0;
        m_cerr = 1'b0; m_ovr = 1'b0;
        e_clk = 1'b0; e_inv = 1'b0; e_abd = 1'b0;
        for (int i = 0; i < PL; i++) dl[i] = 1'b0;
        beat_no = 0;
    endtask

    task automatic model_edge(input logic pv, input logic fs, input logic de, input logic ab);
        int ret_old;
        e_clk = 1'b0; e_inv = 1'b0; e_abd = 1'b0;
        if ((fs && m_ph != P_IDLE) || (de && m_ph == P_IDLE)) m_ovr = 1'b1;
        if (ab && (m_ph == P_ACC || m_ph == P_FLUSH)) begin
            m_ph = P_IDLE; m_n = 0; m_iss = 0; m_ret = 0; e_abd = 1'b1;
            return;
        end
        ret_old = m_ret;
        if (de && m_ph != P_IDLE) m_ret++;
        case (m_ph)
            P_IDLE: if (fs) begin
                m_ph = P_ACC; m_n = 0; m_iss = 0; m_ret = 0; m_cerr = 1'b0;
            end
            P_ACC: if (pv) begin
                e_clk = 1'b1;
                e_inv = bdr(m_n);
                if (!e_inv) m_iss++;
                m_n++;
                if (m_n == NPIX) begin
                    m_ph = P_FLUSH; m_idle = 0;
                end
            end
            P_FLUSH: begin
                if (ret_old == m_iss) begin
                    m_ph = P_DONE;
                    if (de) m_cerr = 1'b1;
                end else if (de) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == PL + SL) begin
                        m_ph = P_DONE; m_cerr = 1'b1;
                    end
                end
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic compare();
        int idx;
        idx = m_n % NPIX;
        chk("col", col, idx % W);
        chk("row", row, idx / W);
        chk("filt_clken", filt_clken, e_clk);
        chk("filt_invalid", filt_invalid, e_inv);
        chk("filt_start", filt_start, (m_ph == P_ACC || m_ph == P_FLUSH));
        chk("busy", busy, m_ph != P_IDLE);
        chk("frame_done", frame_done, m_ph == P_DONE);
        chk("cnt_err", cnt_err, m_cerr);
        chk("ovr_err", ovr_err, m_ovr);
`ifdef GRAD_SEQ_ABORT_EN
        chk("abort_done", abort_done, e_abd);
        n_abd += abort_done;
`endif
        n_clk  += filt_clken;
        n_val  += (filt_clken && !filt_invalid);
        n_inv  += (filt_clken && filt_invalid);
        n_done += frame_done;
    endtask

    task automatic cyc(input logic pv, input logic fs, input logic inj, input logic ab);
        logic beat;
        pix_valid    = pv;
        frame_start  = fs;
        filt_data_en = dl[PL-1] | inj;
`ifdef GRAD_SEQ_ABORT_EN
        abort = ab;
`endif
        n_de += filt_data_en;
        @(posedge clk);
        model_edge(pv, fs, filt_data_en, ab);
        @(negedge clk);
        compare();
        beat = filt_clken && !filt_invalid;
        if (beat) begin
            beat_no++;
            if (beat_no == drop_idx) beat = 1'b0;
        end
        for (int i = PL - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = beat;
    endtask

    // mode: 0 continuous, 1 toggling pix_valid, 2 frame_start mid-RUN, 3 abort at row 4 col 2
    task automatic run_frame(input int mode);
        logic pv, fs, ab;
        int c;
        n_clk = 0; n_val = 0; n_inv = 0; n_done = 0; n_de = 0; n_abd = 0; beat_no = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (c = 0; c < 2000 && m_ph != P_IDLE; c++) begin
            pv = (mode == 1) ? ((c % 2) == 0) : 1'b1;
            fs = (mode == 2 && c == 20);
            ab = (mode == 3 && m_ph == P_ACC && m_n == 4 * W + 2);
            cyc(pv, fs, 1'b0, ab);
        end
        if (m_ph != P_IDLE) chk("frame_timeout", 1, 0);
    endtask

    task automatic hard_reset();
        pix_valid = 1'b0; frame_start = 1'b0; filt_data_en = 1'b0;
`ifdef GRAD_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_outs", {filt_start, filt_clken, filt_invalid, busy, frame_done, cnt_err, ovr_err}, 0);
        chk("rst_pos", {col, row}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drop_idx = 0;
        @(negedge clk);
        hard_reset();

        // Frame A: continuous pixels, every beat returned.
        run_frame(0);
        chk("A_clkens", n_clk, 48);
        chk("A_valid_windows", n_val, 24);
        chk("A_returned_beats", n_de, 24);
        chk("A_frame_done", n_done, 1);
        chk("A_cnt_err", cnt_err, 0);

        // Frame B: pix_valid toggling.
        run_frame(1);
        chk("B_clkens", n_clk, 48);
        chk("B_border_windows", n_inv, 24);
        chk("B_valid_windows", n_val, 24);
        chk("B_frame_done", n_done, 1);

        // Frame C: filter drops the fifth valid beat, drain times out.
        drop_idx = 5;
        run_frame(0);
        drop_idx = 0;
        chk("C_returned_beats", n_de, 23);
        chk("C_cnt_err", cnt_err, 1);
        chk("C_frame_done", n_done, 1);

        // Frame D: frame_start during RUN, then a stray data_en in IDLE.
        run_frame(2);
        chk("D_frame_done", n_done, 1);
        chk("D_cnt_err_cleared", cnt_err, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("D_ovr_err", ovr_err, 1);

        // Reset in the middle of row 3, then a clean frame.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 200 && m_n < 3 * W + 1; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("R_reached_row3", row, 3);
        hard_reset();
        run_frame(0);
        chk("E_valid_windows", n_val, 24);
        chk("E_cnt_err", cnt_err, 0);
        chk("E_ovr_err", ovr_err, 0);
        chk("E_frame_done", n_done, 1);

`ifdef GRAD_SEQ_ABORT_EN
        run_frame(3);
        for (int i = 0; i < PL; i++) dl[i] = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("F_abort_done_pulses", n_abd, 1);
        chk("F_no_frame_done", n_done, 0);
        chk("F_busy", busy, 0);
        chk("F_pos_cleared", {col, row}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
